// File: rtl/store_ctrl.sv
// Context store: saves the register-bank snapshot into one of 2^SEG_W segments
// and replays a segment back to the bank through a one-word-per-cycle restore port.
module store_ctrl #(
  parameter int DW    = 16,
  parameter int SEG_W = 4,
  parameter int WORDS = 4,
  parameter int IW    = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  store_write,
  input  logic                  store_read,
  input  logic [SEG_W-1:0]      SA,
  input  logic [SEG_W-1:0]      SB,
  input  logic [WORDS*DW-1:0]   snap_in,
  output logic                  store_busy,
  output logic                  rst_we,
  output logic [IW-1:0]         rst_idx,
  output logic [DW-1:0]         rst_data,
  output logic                  store_err,
  output logic [2**SEG_W-1:0]   seg_valid
);

  localparam int SEGS  = 2**SEG_W;
  localparam int AW    = SEG_W + IW;
  localparam int DEPTH = SEGS * WORDS;

  typedef enum logic [2:0] {IDLE, SAVE, LOAD, LDLAST, DONE} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        cnt;
  logic [SEG_W-1:0]     seg;
  logic [WORDS*DW-1:0]  snap;
  logic [DW-1:0]        mem [DEPTH];
  logic [AW-1:0]        mem_addr;

  logic latch_save, latch_load, cnt_inc, mem_we, set_valid, load_issue, err_n;
  logic cnt_last;

  assign cnt_last = (cnt == IW'(WORDS - 1));
  assign mem_addr = AW'(seg) * AW'(WORDS) + AW'(cnt);

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    store_busy = 1'b0;
    latch_save = 1'b0;
    latch_load = 1'b0;
    cnt_inc    = 1'b0;
    mem_we     = 1'b0;
    set_valid  = 1'b0;
    load_issue = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (store_write) begin
          store_busy = 1'b1;
          latch_save = 1'b1;
          state_n    = SAVE;
        end else if (store_read) begin
          store_busy = 1'b1;
          if (seg_valid[SB]) begin
            latch_load = 1'b1;
            state_n    = LOAD;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      SAVE: begin
        store_busy = 1'b1;
        mem_we     = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_last) begin
          set_valid = 1'b1;
          state_n   = DONE;
        end
      end
      LOAD: begin
        store_busy = 1'b1;
        load_issue = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_last) state_n = LDLAST;
      end
      LDLAST: begin
        store_busy = 1'b1;
        state_n    = DONE;
      end
      // DONE drops busy so the core advances; its stale request is ignored here.
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      seg       <= '0;
      snap      <= '0;
      rst_we    <= 1'b0;
      rst_idx   <= '0;
      rst_data  <= '0;
      store_err <= 1'b0;
      seg_valid <= '0;
    end else begin
      state     <= state_n;
      store_err <= err_n;
      rst_we    <= load_issue;
      if (latch_save) begin
        snap <= snap_in;
        seg  <= SA;
        cnt  <= '0;
      end else if (latch_load) begin
        seg <= SB;
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + IW'(1);
      end
      if (load_issue) begin
        rst_idx  <= cnt;
        rst_data <= mem[mem_addr];
      end
      if (set_valid) seg_valid[seg] <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; seg_valid alone says which contents are meaningful.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= snap[int'(cnt) * DW +: DW];
  end

endmodule

// File: doc/store_ctrl.md
Name: store_ctrl

Overview:
- Context store unit; the responder to the core's SAVE/LOAD requests (store_write/store_read, SA/SB, store_busy).
- Holds 2^SEG_W context segments of WORDS data words each.
- SAVE: snapshots the register bank into segment SA.
- LOAD: replays segment SB back to the register bank, one word per cycle, via a restore write port.
- Holds store_busy high so the core stalls its IP until the operation completes.

Parameters:
- DW, 16: data word width; equals the core data width.
- SEG_W, 4: segment select width; 16 segments.
- WORDS, 4: words per context (AX, BX, CX, DX order, index 0..3).
- IW, 2: index width; equals clog2(WORDS).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- store_write  in  1  SAVE request from core; level, held while store_busy=1.
- store_read  in  1  LOAD request from core; level, held while store_busy=1.
- SA  in  SEG_W  target segment for SAVE.
- SB  in  SEG_W  source segment for LOAD.
- snap_in  in  WORDS*DW  register snapshot; word i at bits [i*DW +: DW].
- store_busy  out  1  stall to core; partly combinational (see Behaviour).
- rst_we  out  1  restore write strobe to the register bank; registered.
- rst_idx  out  IW  restore register index; registered.
- rst_data  out  DW  restore data; registered.
- store_err  out  1  one-cycle pulse: LOAD of a never-saved segment; registered.
- seg_valid  out  2^SEG_W  per-segment "has been saved" flags.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE; counter=0.
  - rst_we=0, rst_idx=0, rst_data=0, store_err=0, seg_valid=0.
  - Storage array is not cleared.
  - Reset mid-operation aborts it. A SAVE aborted mid-way leaves seg_valid unchanged for that segment; its partial words are don't-care.
- States: IDLE, SAVE, LOAD, LDLAST, DONE.
- store_busy = (IDLE & (store_write | store_read)) | SAVE | LOAD | LDLAST. It is 0 in DONE.
- IDLE:
  - store_write=1 → latch snap_in and SA; counter=0; go to SAVE.
  - Else store_read=1 and seg_valid[SB]=1 → latch SB; counter=0; go to LOAD.
  - Else store_read=1 and seg_valid[SB]=0 → store_err=1 for the next cycle; go to DONE (busy only in the request cycle).
  - Both requests asserted → SAVE wins; read ignored.
- SAVE:
  - Each cycle write latched word[counter] to mem[seg*WORDS + counter]; counter++.
  - On counter=WORDS-1: set seg_valid[seg]; go to DONE.
  - Busy duration: request cycle + WORDS cycles.
  - Snapshot is latched at the request edge; snap_in changes after that have no effect.
- LOAD:
  - Each cycle register rst_we=1, rst_idx=counter, rst_data=mem[seg*WORDS + counter]; counter++.
  - After counter=WORDS-1 go to LDLAST.
  - rst_we therefore appears in the cycle after each LOAD cycle.
- LDLAST: rst_we carries the last word (idx WORDS-1); go to DONE.
- LOAD timing:
  - Request at t0.
  - rst_we high t2..t(WORDS+1); indices 0..WORDS-1 ascending, exactly WORDS pulses.
  - store_busy high t0..t(WORDS+1).
  - DONE at t(WORDS+2).
- DONE:
  - busy=0, so the core advances IP on this edge.
  - Requests are ignored (the core still presents the old command this cycle).
  - Unconditionally return to IDLE.
- rst_we=0 in all states except LOAD-issued cycles. rst_data/rst_idx hold their last values when rst_we=0.
- Address arithmetic: seg*WORDS + counter, width SEG_W+IW; no wrap between segments.
- A SAVE to an already-valid segment overwrites it; seg_valid stays 1.
- LOAD from the segment just saved in the immediately previous operation returns the new data (no write/read hazard, since DONE separates them).

Test Plan:
- Reset then SAVE:
  - RESET low mid-SAVE (after 2 words), release → all outputs 0, seg_valid=0, state IDLE, store_busy=0 with no request.
- SAVE:
  - snap_in={DX=0x4444, CX=0x3333, BX=0x2222, AX=0x1111}, SA=3, store_write held while busy → store_busy high exactly 5 cycles (t0..t4), 0 at t5; seg_valid=0x0008.
  - snap_in changed to all 0xFFFF at t1 → no effect on stored data.
- LOAD after SAVE:
  - store_read, SB=3 → rst_we at t2..t5 with (idx, data) = (0,0x1111), (1,0x2222), (2,0x3333), (3,0x4444).
  - store_busy high t0..t5, 0 at t6; store_err stays 0.
- LOAD of empty segment: store_read, SB=7, seg_valid[7]=0 → store_busy high only at t0, store_err=1 at t1, no rst_we pulse.
- Simultaneous request: store_write=1 and store_read=1, SA=5, SB=3 → SAVE to segment 5 (seg_valid[5]=1), no rst_we pulse; DONE cycle ignores the still-held requests (no second SAVE).
- Back-to-back: SAVE SA=1 with 0xA0..0xA3, DONE, then SAVE SA=1 with 0xB0..0xB3, then LOAD SB=1 → restored data 0xB0..0xB3 (overwrite works).
